// File: rtl/data_separator_pkg.sv
// Shared types and sizing helpers for the word-to-byte serialiser.
// Keeps the byte-count and index-width rules in one place for the top and the bench.
package data_separator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

  // A one-byte word still needs a 1-bit index so the register is never zero-width.
  function automatic int byte_idx_w(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/data_separator_fifo_if.sv
// Push side, byte stream to the UART transmitter, and status flags of the separator.
interface data_separator_fifo_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] data_i;
  logic              valid_pulse_i;
  logic              msb_first_i;
  logic [7:0]        data_o;
  logic              valid_o;
  logic              ready;
  logic              full_o;
  logic              empty_o;
  logic [CNT_W-1:0]  count_o;
  logic              overflow_o;
  logic              busy_o;

  modport slave (
    input  data_i, valid_pulse_i, msb_first_i, ready,
    output data_o, valid_o, full_o, empty_o, count_o, overflow_o, busy_o
  );

  modport master (
    output data_i, valid_pulse_i, msb_first_i, ready,
    input  data_o, valid_o, full_o, empty_o, count_o, overflow_o, busy_o
  );

endinterface

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO; head word is visible on rd_data without a read cycle so
// the serialiser can pop and load in the same clock.
module sync_word_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         rd_en,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              wr_ok;
  logic              rd_ok;

  // A push while full is refused even if a pop frees a slot this cycle.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);

endmodule

// File: rtl/data_separator_fifo.sv
// Buffers words in a FIFO and streams each one out as bytes over valid/ready,
// with the byte order latched per word at load time.
module data_separator_fifo
  import data_separator_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rstn,
  data_separator_fifo_if.slave bus
);
  localparam int BYTES = bytes_per_word(DATA_W);
  localparam int IDX_W = byte_idx_w(BYTES);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic              msb_reg, msb_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic              overflow_reg;

  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  logic [7:0]        byte_lanes [BYTES];
  logic [IDX_W-1:0]  lane_sel;

  sync_word_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (bus.valid_pulse_i),
    .wr_data (bus.data_i),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_reg <= 1'b0;
    end else if (bus.valid_pulse_i && fifo_full) begin
      overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      msb_reg   <= 1'b0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      msb_reg   <= msb_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    msb_next   = msb_reg;
    idx_next   = idx_reg;
    fifo_rd_en = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          shift_next = fifo_rd_data;
          msb_next   = bus.msb_first_i;
          idx_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (bus.ready) begin
          if (idx_reg == LAST_IDX) begin
            state_next = IDLE;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lanes
    assign byte_lanes[gi] = shift_reg[gi*8 +: 8];
  end

  // Lane 0 is the least significant byte; MSB-first walks the lanes downwards.
  assign lane_sel = msb_reg ? (LAST_IDX - idx_reg) : idx_reg;

  assign bus.data_o     = (state_reg == SEND) ? byte_lanes[lane_sel] : 8'h00;
  assign bus.valid_o    = (state_reg == SEND);
  assign bus.busy_o     = (state_reg == SEND);
  assign bus.full_o     = fifo_full;
  assign bus.empty_o    = fifo_empty;
  assign bus.count_o    = fifo_count;
  assign bus.overflow_o = overflow_reg;

endmodule
